// File: rtl/mpi_reduce_engine.sv
// Multi-slot collective reduction engine: folds per-rank contributions keyed by
// (contextId, tag) and emits one registered result once the whole group has contributed.
module mpi_reduce_engine #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned MAX_RANKS = 8,
    parameter int unsigned RANK_W    = 9,
    parameter int unsigned CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [RANK_W-1:0] rank,
    input  logic [7:0]        contextId,
    input  logic [7:0]        tag,
    input  logic [3:0]        op,
    input  logic [CNT_W-1:0]  group_size,
    input  logic [DATA_W-1:0] payload,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [7:0]        out_contextId,
    output logic [7:0]        out_tag,
    output logic [3:0]        out_op,
    output logic [DATA_W-1:0] out_result,
    output logic              done,
    output logic              err
);

    localparam int unsigned SIDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned RIDX_W = (MAX_RANKS > 1) ? $clog2(MAX_RANKS) : 1;

    localparam logic [3:0] OpSum = 4'b1000;
    localparam logic [3:0] OpMax = 4'b1001;
    localparam logic [3:0] OpMin = 4'b1010;
    localparam logic [3:0] OpAnd = 4'b1011;
    localparam logic [3:0] OpOr  = 4'b1100;
    localparam logic [3:0] OpXor = 4'b1101;

    typedef logic [SIDX_W-1:0] sidx_t;

    function automatic logic op_legal(input logic [3:0] f);
        return f inside {OpSum, OpMax, OpMin, OpAnd, OpOr, OpXor};
    endfunction

    function automatic logic [DATA_W-1:0] reduce_op(input logic [3:0]        f,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        r = '0;
        case (f)
            OpSum:   r = a + b;
            OpMax:   r = ($signed(a) > $signed(b)) ? a : b;
            OpMin:   r = ($signed(a) < $signed(b)) ? a : b;
            OpAnd:   r = a & b;
            OpOr:    r = a | b;
            OpXor:   r = a ^ b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Per-slot state
    logic [NUM_SLOTS-1:0] vld_q, vld_d;
    logic [7:0]           ctx_q [NUM_SLOTS];
    logic [7:0]           ctx_d [NUM_SLOTS];
    logic [7:0]           tag_q [NUM_SLOTS];
    logic [7:0]           tag_d [NUM_SLOTS];
    logic [3:0]           op_q  [NUM_SLOTS];
    logic [3:0]           op_d  [NUM_SLOTS];
    logic [CNT_W-1:0]     gsz_q [NUM_SLOTS];
    logic [CNT_W-1:0]     gsz_d [NUM_SLOTS];
    logic [CNT_W-1:0]     cnt_q [NUM_SLOTS];
    logic [CNT_W-1:0]     cnt_d [NUM_SLOTS];
    logic [DATA_W-1:0]    acc_q [NUM_SLOTS];
    logic [DATA_W-1:0]    acc_d [NUM_SLOTS];
    logic [MAX_RANKS-1:0] bmp_q [NUM_SLOTS];
    logic [MAX_RANKS-1:0] bmp_d [NUM_SLOTS];

    // Output register
    logic              out_vld_q, out_vld_d;
    logic [7:0]        out_ctx_q, out_ctx_d;
    logic [7:0]        out_tag_q, out_tag_d;
    logic [3:0]        out_op_q, out_op_d;
    logic [DATA_W-1:0] out_res_q, out_res_d;
    logic              err_q, err_d;

    logic [NUM_SLOTS-1:0] fin;
    logic                 hit, free_any, fin_any;
    sidx_t                hit_idx, free_idx, fin_idx;

    // A finished slot no longer matches lookups; it waits only to move into the output register.
    always_comb begin
        fin      = '0;
        hit      = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        fin_any  = 1'b0;
        fin_idx  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            fin[i] = vld_q[i] && (cnt_q[i] == gsz_q[i]);
            if (!hit && vld_q[i] && !fin[i] && ctx_q[i] == contextId && tag_q[i] == tag) begin
                hit     = 1'b1;
                hit_idx = sidx_t'(i);
            end
            if (!free_any && !vld_q[i]) begin
                free_any = 1'b1;
                free_idx = sidx_t'(i);
            end
            if (!fin_any && fin[i]) begin
                fin_any = 1'b1;
                fin_idx = sidx_t'(i);
            end
        end
    end

    logic [3:0]           sel_op;
    logic [CNT_W-1:0]     sel_gsz;
    logic [MAX_RANKS-1:0] sel_bmp;
    logic [31:0]          rank_w, gsz_w;
    logic [RIDX_W-1:0]    ridx;
    logic                 rank_in, drop, stall, accept, out_can, load;

    always_comb begin
        sel_op  = hit ? op_q[hit_idx] : op;
        sel_gsz = hit ? gsz_q[hit_idx] : group_size;
        sel_bmp = hit ? bmp_q[hit_idx] : '0;
        rank_w  = 32'(rank);
        gsz_w   = 32'(sel_gsz);
        ridx    = rank[RIDX_W-1:0];
        rank_in = rank_w < MAX_RANKS;
        drop    = !op_legal(op)
                || (!hit && group_size == '0)
                || !rank_in
                || (rank_w >= gsz_w)
                || (hit && op != sel_op)
                || (rank_in && sel_bmp[ridx]);
        stall    = out_vld_q && !ready_out;
        ready_in = (hit || free_any) && !stall;
        accept   = valid_in && ready_in;
        out_can  = !out_vld_q || ready_out;
        load     = fin_any && out_can;
    end

    always_comb begin
        vld_d = vld_q;
        ctx_d = ctx_q;
        tag_d = tag_q;
        op_d  = op_q;
        gsz_d = gsz_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        bmp_d = bmp_q;
        if (accept && !drop) begin
            if (hit) begin
                acc_d[hit_idx]       = reduce_op(op_q[hit_idx], acc_q[hit_idx], payload);
                cnt_d[hit_idx]       = cnt_q[hit_idx] + CNT_W'(1);
                bmp_d[hit_idx][ridx] = 1'b1;
            end else begin
                vld_d[free_idx]       = 1'b1;
                ctx_d[free_idx]       = contextId;
                tag_d[free_idx]       = tag;
                op_d[free_idx]        = op;
                gsz_d[free_idx]       = group_size;
                cnt_d[free_idx]       = CNT_W'(1);
                acc_d[free_idx]       = payload;
                bmp_d[free_idx]       = '0;
                bmp_d[free_idx][ridx] = 1'b1;
            end
        end
        if (load) begin
            vld_d[fin_idx] = 1'b0;
        end
    end

    // A drain and a fresh load may coincide; the new result simply overwrites the old one.
    always_comb begin
        out_vld_d = out_vld_q && !ready_out;
        out_ctx_d = out_ctx_q;
        out_tag_d = out_tag_q;
        out_op_d  = out_op_q;
        out_res_d = out_res_q;
        if (load) begin
            out_vld_d = 1'b1;
            out_ctx_d = ctx_q[fin_idx];
            out_tag_d = tag_q[fin_idx];
            out_op_d  = op_q[fin_idx];
            out_res_d = acc_q[fin_idx];
        end
        err_d = accept && drop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                ctx_q[i] <= '0;
                tag_q[i] <= '0;
                op_q[i]  <= '0;
                gsz_q[i] <= '0;
                cnt_q[i] <= '0;
                acc_q[i] <= '0;
                bmp_q[i] <= '0;
            end
            out_vld_q <= 1'b0;
            out_ctx_q <= '0;
            out_tag_q <= '0;
            out_op_q  <= '0;
            out_res_q <= '0;
            err_q     <= 1'b0;
        end else begin
            vld_q     <= vld_d;
            ctx_q     <= ctx_d;
            tag_q     <= tag_d;
            op_q      <= op_d;
            gsz_q     <= gsz_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            bmp_q     <= bmp_d;
            out_vld_q <= out_vld_d;
            out_ctx_q <= out_ctx_d;
            out_tag_q <= out_tag_d;
            out_op_q  <= out_op_d;
            out_res_q <= out_res_d;
            err_q     <= err_d;
        end
    end

    assign valid_out     = out_vld_q;
    assign out_contextId = out_ctx_q;
    assign out_tag       = out_tag_q;
    assign out_op        = out_op_q;
    assign out_result    = out_res_q;
    assign done          = out_vld_q && ready_out;
    assign err           = err_q;

endmodule

// File: tb/tb_mpi_reduce_engine.sv
// Scoreboard bench for mpi_reduce_engine: directed packets push expected results,
// a forked monitor pops and compares them on each output handshake.
module tb_mpi_reduce_engine;

    localparam logic [3:0] SUM = 4'b1000;
    localparam logic [3:0] MAX = 4'b1001;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        ready_in;
    logic [8:0]  rank;
    logic [7:0]  contextId;
    logic [7:0]  tag;
    logic [3:0]  op;
    logic [3:0]  group_size;
    logic [31:0] payload;
    logic        valid_out;
    logic        ready_out;
    logic [7:0]  out_contextId;
    logic [7:0]  out_tag;
    logic [3:0]  out_op;
    logic [31:0] out_result;
    logic        done;
    logic        err;

    mpi_reduce_engine dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .ready_in     (ready_in),
        .rank         (rank),
        .contextId    (contextId),
        .tag          (tag),
        .op           (op),
        .group_size   (group_size),
        .payload      (payload),
        .valid_out    (valid_out),
        .ready_out    (ready_out),
        .out_contextId(out_contextId),
        .out_tag      (out_tag),
        .out_op       (out_op),
        .out_result   (out_result),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  ctx;
        logic [7:0]  tg;
        logic [31:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   exp_pushed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic push_exp(input logic [7:0] c, input logic [7:0] t, input logic [31:0] r);
        exp_t e;
        e.ctx = c;
        e.tg  = t;
        e.res = r;
        exp_q.push_back(e);
        exp_pushed++;
    endtask

    // Called just after a rising edge; returns just after the edge that transferred the packet.
    task automatic send(input logic [8:0] r, input logic [7:0] c, input logic [7:0] t,
                        input logic [3:0] o, input logic [3:0] g, input logic [31:0] p);
        int n;
        n = 0;
        rank = r; contextId = c; tag = t; op = o; group_size = g; payload = p;
        valid_in = 1'b1;
        #1;
        while (!ready_in && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready_in) begin
            chk("send_ready", 32'(ready_in), 32'd1);
            valid_in = 1'b0;
        end else begin
            @(posedge clk); #1;
            valid_in = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    logic [31:0] sum6 [6];
    logic [31:0] mx [6];
    int d0, e0;

    initial begin
        sum6[0] = 6; sum6[1] = 5; sum6[2] = 4; sum6[3] = 3; sum6[4] = 2; sum6[5] = 1;
        mx[0] = 7; mx[1] = -9; mx[2] = -3; mx[3] = -1; mx[4] = 2; mx[5] = -4;
        rst = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
        rank = '0; contextId = '0; tag = '0; op = '0; group_size = '0; payload = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_ctx", 32'(out_contextId), 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready_in", 32'(ready_in), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (done) done_cnt++;
                if (err) err_cnt++;
                if (valid_out && ready_out) begin
                    chk("result_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("res_ctx", 32'(out_contextId), 32'(e.ctx));
                        chk("res_tag", 32'(out_tag), 32'(e.tg));
                        chk("res_value", out_result, e.res);
                    end
                end
            end
            begin
                #200000;
                $display("FAIL watchdog: got timeout want finish");
                $fatal(1, "watchdog");
            end
        join_none

        // SUM over six ranks, back to back, with latency check
        push_exp(8'd0, 8'd1, 32'd21);
        d0 = done_cnt;
        for (int i = 0; i < 6; i++) send(9'(i), 8'd0, 8'd1, SUM, 4'd6, sum6[i]);
        chk("sum_latency_early", 32'(valid_out), 32'd0);
        @(posedge clk); #1;
        chk("sum_valid_out", 32'(valid_out), 32'd1);
        chk("sum_out_result", out_result, 32'd21);
        chk("sum_out_op", 32'(out_op), 32'(SUM));
        @(posedge clk); #1;
        chk("sum_valid_drop", 32'(valid_out), 32'd0);
        chk("sum_done_once", 32'(done_cnt - d0), 32'd1);

        // Interleaved signed MAX on tags 1 and 2
        push_exp(8'd0, 8'd1, 32'd7);
        push_exp(8'd0, 8'd2, 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) send(9'(i / 2), 8'd0, 8'(1 + i % 2), MAX, 4'd3, mx[i]);
        wait_drain();

        // Duplicate rank and op mismatch are dropped without disturbing the slot
        push_exp(8'd0, 8'd3, 32'd8);
        e0 = err_cnt;
        send(9'd0, 8'd0, 8'd3, SUM, 4'd3, 32'd1);
        send(9'd2, 8'd0, 8'd3, SUM, 4'd3, 32'd5);
        chk("no_err_ok_pkt", 32'(err), 32'd0);
        send(9'd2, 8'd0, 8'd3, SUM, 4'd3, 32'd5);
        chk("err_dup", 32'(err), 32'd1);
        send(9'd1, 8'd0, 8'd3, MAX, 4'd3, 32'd9);
        chk("err_op_mismatch", 32'(err), 32'd1);
        send(9'd1, 8'd0, 8'd3, SUM, 4'd3, 32'd2);
        chk("no_err_final", 32'(err), 32'd0);
        wait_drain();

        // Illegal packets on fresh tags: bad op, rank beyond MAX_RANKS, zero group, rank >= group
        send(9'd0, 8'd1, 8'd30, 4'b0111, 4'd2, 32'd1);
        chk("err_bad_op", 32'(err), 32'd1);
        send(9'd9, 8'd1, 8'd31, SUM, 4'd2, 32'd1);
        chk("err_rank_max", 32'(err), 32'd1);
        send(9'd0, 8'd1, 8'd32, SUM, 4'd0, 32'd1);
        chk("err_gsz0", 32'(err), 32'd1);
        send(9'd3, 8'd1, 8'd33, SUM, 4'd2, 32'd1);
        chk("err_rank_gsz", 32'(err), 32'd1);
        @(posedge clk); #1;
        chk("err_count", 32'(err_cnt - e0), 32'd6);

        // Slot exhaustion: four partial groups, a fifth tag stalls until one completes
        push_exp(8'd5, 8'd10, 32'd101);
        push_exp(8'd5, 8'd14, 32'd50);
        push_exp(8'd5, 8'd11, 32'd102);
        push_exp(8'd5, 8'd12, 32'd103);
        push_exp(8'd5, 8'd13, 32'd104);
        for (int i = 0; i < 4; i++) send(9'd0, 8'd5, 8'(10 + i), SUM, 4'd2, 32'(i + 1));
        rank = 9'd0; contextId = 8'd5; tag = 8'd14; op = SUM; group_size = 4'd1;
        payload = 32'd50; valid_in = 1'b1;
        #1;
        chk("full_ready_in", 32'(ready_in), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("full_ready_hold", 32'(ready_in), 32'd0);
        send(9'd1, 8'd5, 8'd10, SUM, 4'd2, 32'd100);
        rank = 9'd0; contextId = 8'd5; tag = 8'd14; op = SUM; group_size = 4'd1;
        payload = 32'd50; valid_in = 1'b1;
        #1;
        chk("free_not_yet", 32'(ready_in), 32'd0);
        @(posedge clk); #1;
        chk("free_ready_in", 32'(ready_in), 32'd1);
        send(9'd0, 8'd5, 8'd14, SUM, 4'd1, 32'd50);
        for (int i = 1; i < 4; i++) send(9'd1, 8'd5, 8'(10 + i), SUM, 4'd2, 32'd100);
        wait_drain();

        // Output backpressure
        ready_out = 1'b0;
        push_exp(8'd7, 8'd20, 32'd77);
        send(9'd0, 8'd7, 8'd20, SUM, 4'd1, 32'd77);
        @(posedge clk); #1;
        chk("bp_valid_out", 32'(valid_out), 32'd1);
        rank = 9'd0; contextId = 8'd7; tag = 8'd21; op = SUM; group_size = 4'd1;
        payload = 32'd1; valid_in = 1'b1;
        #1;
        chk("bp_ready_in", 32'(ready_in), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_stable", out_result, 32'd77);
        end
        chk("bp_no_done", 32'(done), 32'd0);
        valid_in = 1'b0;
        ready_out = 1'b1;
        #1;
        chk("bp_done_hi", 32'(done), 32'd1);
        @(posedge clk); #1;
        chk("bp_done_lo", 32'(done), 32'd0);
        chk("bp_valid_lo", 32'(valid_out), 32'd0);

        // Reset mid-collective leaves no residue
        for (int i = 0; i < 3; i++) send(9'(i), 8'd0, 8'd1, SUM, 4'd6, sum6[i]);
        rst = 1'b0;
        #2;
        chk("mid_rst_valid", 32'(valid_out), 32'd0);
        chk("mid_rst_ready", 32'(ready_in), 32'd1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        push_exp(8'd0, 8'd1, 32'd21);
        for (int i = 0; i < 6; i++) send(9'(i), 8'd0, 8'd1, SUM, 4'd6, sum6[i]);
        wait_drain();

        chk("done_count", 32'(done_cnt), 32'(exp_pushed));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mpi_reduce_engine.md
Name: mpi_reduce_engine

Overview:
- Multi-slot collective reduction engine for the MPI collective router.
- Accepts per-rank contribution packets tagged by (contextId, tag) and combines their payloads with the packet's reduction op.
- Emits one result packet when every rank of the group has contributed.
- Generalises the single-stream reduce path: configurable data width, concurrent collectives, group size and op set, with ready/valid backpressure and duplicate/illegal-rank detection.

Parameters:
- DATA_W, 32, payload and accumulator width.
- NUM_SLOTS, 4, concurrent in-flight collectives (distinct contextId/tag pairs).
- MAX_RANKS, 8, maximum group size; width of the per-slot rank bitmap.
- RANK_W, 9, rank field width.
- CNT_W, 4, group-size and counter width; must satisfy 2^CNT_W > MAX_RANKS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_in  in  1  contribution valid.
- ready_in  out  1  engine can accept; transfer occurs when valid_in && ready_in.
- rank  in  RANK_W  contributing rank.
- contextId  in  8  communicator context.
- tag  in  8  collective tag.
- op  in  4  reduction op.
- group_size  in  CNT_W  contributions expected; sampled only on slot allocation.
- payload  in  DATA_W  contribution.
- valid_out  out  1  result valid.
- ready_out  in  1  downstream accepts result.
- out_contextId  out  8  result context.
- out_tag  out  8  result tag.
- out_op  out  4  result op.
- out_result  out  DATA_W  reduced value.
- done  out  1  one-cycle pulse on the result handshake.
- err  out  1  one-cycle pulse when an accepted packet is dropped.

Behaviour:
- Reset (rst=0, async): all slots invalid; valid_out=0, done=0, err=0, all out_* = 0; ready_in reads 1 once reset is released.
- Op encoding:
  - 4'b1000 SUM (wraps mod 2^DATA_W).
  - 4'b1001 MAX (signed).
  - 4'b1010 MIN (signed).
  - 4'b1011 AND.
  - 4'b1100 OR.
  - 4'b1101 XOR.
  - Any other value is illegal.
- Slot state: valid, contextId, tag, op, group_size, count, acc, rank bitmap[MAX_RANKS].
- Lookup: a hit is a valid slot with matching contextId and tag. On a miss, the lowest-index free slot is allocated.
- ready_in = (hit || free slot exists) && !(valid_out && !ready_out). This is combinational from the inputs and state.
- Accepted packet dropped with err=1 the next cycle, slot state unchanged, if any of:
  - illegal op;
  - group_size==0 on allocate;
  - rank >= MAX_RANKS;
  - rank >= the slot's group_size;
  - rank bit already set (duplicate);
  - on a hit, op differs from the slot's op.
- Allocate: acc=payload, count=1, bitmap = only the rank bit set, op and group_size latched.
- Hit: acc = op(acc, payload), count+1, rank bit set.
- Completion: when the updated count equals group_size (including group_size=1 on allocate):
  - on the next edge, the result loads the output register, valid_out=1, and the slot is freed that same edge;
  - the slot is reusable from the following cycle.
- Output register holds stable until valid_out && ready_out. In that cycle done=1; valid_out drops next cycle unless a new completion loads in the same cycle.
- Simultaneous drain and new completion in one cycle: allowed. The new result replaces the old one, valid_out stays 1, and done pulses for the old result.
- Latency: completing contribution accepted at edge N gives valid_out=1 after edge N+1 (one register stage).
- All slots busy and the incoming tag misses: ready_in=0 until a slot frees. No reordering, no drop.
- Reset mid-collective discards all partial accumulations and any pending result.

Test Plan:
- SUM, ctx=0, tag=1, group_size=6, ranks 0..5 with payloads 6,5,4,3,2,1 back-to-back, ready_out=1 -> valid_out one cycle after the last accept, out_result=21, done pulses once.
- Interleaved tags 1 and 2, op MAX, group_size=3:
  - tag1 payloads 7, -3, 2;
  - tag2 payloads -9, -1, -4 (signed);
  - result: two results, tag1=7 and tag2=-1, in completion order.
- Duplicate rank 2 sent twice in SUM group_size=3 (5,5,then 1 from rank 4? no) -> use payloads rank0=1, rank2=5, rank2=5, rank1=2 -> err pulses on the third packet, result=8.
- Fill NUM_SLOTS=4 with distinct tags, each missing one contribution, then send a fifth tag -> ready_in=0. Complete tag 0 -> ready_in returns to 1 two cycles later and the fifth tag allocates.
- Hold ready_out=0 while a result is pending -> ready_in=0, out_* stable; raise ready_out -> done=1 for exactly one cycle.
- Drop rst low mid-group (3 of 6 SUM contributions sent), then release and resend the full group 6..1 -> out_result=21 (no residue).
